// File: rtl/ascii_capture.sv
// ascii_capture: paced CPU character sink that records 7-bit text into a buffer read back over the host upload port.
// ADDR_W must stay below 16 so the full count 2**ADDR_W fits in capture_len.
module ascii_capture #(
  parameter int ADDR_W = 12,
  parameter int PACE = 4000
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic        address,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        clear,
  input  logic        ioctl_upload,
  input  logic [15:0] upload_addr,
  output logic [7:0]  upload_dout,
  output logic [15:0] capture_len,
  output logic        overflow
);
  localparam logic [15:0] DEPTH = 16'(2 ** ADDR_W);
  localparam logic [15:0] PACE_LD = 16'(PACE - 1);
  typedef enum logic [1:0] {S_IDLE, S_PACE, S_FROZEN} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_len;
  logic        r_ovf;
  logic [7:0]  r_dout;
  logic [7:0]  r_up;
  logic [7:0]  r_mem [2 ** ADDR_W];
  logic        w_busy, w_full, w_acc, w_store;
  logic [7:0]  w_lo, w_byte;
  assign w_busy = r_state != S_IDLE;
  assign w_full = r_len == DEPTH;
  assign w_acc = cs & we & ~address & ~ioctl_upload & (r_state != S_FROZEN);
  assign w_store = w_acc & ~clear & ~w_full;
  assign w_lo = din & 8'h7F;
  assign w_byte = (w_lo == 8'h0D) ? 8'h0A : w_lo;
  assign dout = r_dout;
  assign upload_dout = r_up;
  assign capture_len = r_len;
  assign overflow = r_ovf;
  // every accepted write, even one dropped by clear or a full buffer, restarts the pace
  always_ff @(posedge clock_in or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else if (ioctl_upload)
      r_state <= S_FROZEN;
    else if (w_acc) begin
      r_state <= S_PACE;
      r_cnt <= PACE_LD;
    end else if (r_state == S_FROZEN)
      r_state <= S_IDLE;
    else if (r_state == S_PACE) begin
      if (r_cnt == 16'd0) r_state <= S_IDLE;
      else r_cnt <= r_cnt - 16'd1;
    end
  always_ff @(posedge clock_in or posedge rst)
    if (rst) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_acc & w_full)
      r_ovf <= 1'b1;
    else if (w_store)
      r_len <= r_len + 16'd1;
  always_ff @(posedge clock_in)
    if (w_store) r_mem[r_len[ADDR_W-1:0]] <= w_byte;
  always_ff @(posedge clock_in or posedge rst)
    if (rst) begin
      r_dout <= 8'h00;
      r_up <= 8'h00;
    end else begin
      if (cs & ~we) r_dout <= address ? {w_busy, w_full, 6'b0} : 8'h00;
      r_up <= (upload_addr < r_len) ? r_mem[upload_addr[ADDR_W-1:0]] : 8'h00;
    end
endmodule

// File: doc/ascii_capture.md
ASCII_CAPTURE -- requirements
Module: ascii_capture

Interface
REQ-001 Parameter ADDR_W, default 12, log2 of capture buffer depth in bytes (4096).
REQ-002 Parameter PACE, default 4000, busy time per accepted character, in clock_in cycles; legal range 2..65535.
REQ-003 clock_in  in  1  system clock (25 MHz).
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cs  in  1  CPU chip select, active high, one-cycle strobe per access.
REQ-006 we  in  1  CPU write enable; qualifies cs.
REQ-007 address  in  1  CPU register select: 0 = TX data, 1 = TX status.
REQ-008 din  in  8  CPU write data.
REQ-009 dout  out  8  CPU read data, registered.
REQ-010 clear  in  1  synchronous pulse that empties the buffer.
REQ-011 ioctl_upload  in  1  host upload window active.
REQ-012 upload_addr  in  16  host read address.
REQ-013 upload_dout  out  8  host read data, registered.
REQ-014 capture_len  out  16  number of valid bytes stored.
REQ-015 overflow  out  1  sticky flag: a character was dropped.

Function
REQ-016 State machine: IDLE, PACE, FROZEN.
REQ-017 IDLE: busy=0. An accepted write (cs & we & address=0 & !ioctl_upload) moves the FSM to PACE and loads the pace counter with PACE-1.
REQ-018 PACE: busy=1. The counter decrements each cycle, and the FSM returns to IDLE the cycle after the counter reads 0, giving exactly PACE busy cycles.
REQ-019 A data write arriving in PACE is still accepted and stored. It restarts the counter at PACE-1 and does not set overflow.
REQ-020 ioctl_upload=1 forces FROZEN from any state.
REQ-021 In FROZEN, busy=1 and CPU data writes are discarded without setting overflow.
REQ-022 When ioctl_upload falls, the FSM goes to IDLE on the next cycle.
REQ-023 Stored byte = {1'b0, din[6:0]}, with 0x0D translated to 0x0A.
REQ-024 Stored bytes are written at index capture_len, and capture_len increments by 1 in the same cycle.
REQ-025 Full condition: capture_len == 2**ADDR_W. A write when full is not stored, sets overflow, and still enters PACE.
REQ-026 CPU read, address=0: dout <= 8'h00.
REQ-027 CPU read, address=1: dout <= {busy, full, 6'b0}, where full is the REQ-025 condition.
REQ-028 dout updates only on cs & !we and holds its value otherwise.
REQ-029 upload_dout is valid 1 cycle after upload_addr.
REQ-030 upload_dout = buffer[upload_addr] when upload_addr < capture_len, else 8'h00.
REQ-031 Upload reads have no side effects, and the buffer contents and capture_len are preserved across an upload.
REQ-032 clear: capture_len <= 0 and overflow <= 0. The FSM state is unchanged.
REQ-033 clear and an accepted data write in the same cycle: clear wins, the byte is discarded, and the FSM still enters PACE.
REQ-034 capture_len saturates at 2**ADDR_W and never wraps.

Reset
REQ-035 rst asserted: FSM=IDLE, pace counter=0, capture_len=0, overflow=0, dout=8'h00, upload_dout=8'h00.
REQ-036 Buffer RAM contents are not cleared by rst; they are unreachable anyway because capture_len=0.
REQ-037 rst asserted mid-PACE or mid-FROZEN returns to IDLE immediately (asynchronous).
REQ-038 After rst deasserts, FROZEN is re-entered on the first clock edge with ioctl_upload=1.

Verification
REQ-039 Write 0xC8 ('H'|0x80) to data, then read status -> 0x80 for 4000 cycles and 0x00 on the following read; buffer[0]=0x48; capture_len=1.
REQ-040 Write 0x8D, then upload addr 0 -> upload_dout=0x0A one cycle later; upload addr 1 -> 0x00.
REQ-041 ADDR_W=2: five writes -> capture_len=4, overflow=1, status read=0xC0 while pacing; clear -> capture_len=0, overflow=0.
REQ-042 With ioctl_upload=1, write 0x41 -> capture_len unchanged, overflow=0, status bit7=1; ioctl_upload falls -> status=0x00 on the second cycle after the fall.
REQ-043 clear coincident with a write of 0x42 -> capture_len=0 and status busy=1; rst pulsed mid-PACE -> status=0x00 and capture_len=0.
